// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared FSM state type and default widths for run_ctrl.
package run_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, ARMED, RUN, DONE} run_state_t;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host/core launch handshake, clear-sweep write port and status of run_ctrl.
interface run_ctrl_if #(
    parameter int ADDR_W = run_ctrl_pkg::ADDR_W_DEF,
    parameter int DATA_W = run_ctrl_pkg::DATA_W_DEF,
    parameter int CNT_W  = run_ctrl_pkg::CNT_W_DEF
) ();
    logic              start;
    logic              halt_req;
    logic              stall;
    logic              pc_rst;
    logic              run_en;
    logic              halt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;
    logic              wdog_to;

    modport master (
        output start, halt_req, stall,
        input  pc_rst, run_en, halt, mem_we, mem_addr, mem_wdata, busy, cycle_cnt, instr_cnt, wdog_to
    );
    modport slave (
        input  start, halt_req, stall,
        output pc_rst, run_en, halt, mem_we, mem_addr, mem_wdata, busy, cycle_cnt, instr_cnt, wdog_to
    );
endinterface

// File: rtl/run_ctrl_sat_cnt.sv
// sat_cnt: up-counter with synchronous clear and increment enable that sticks at all-ones.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: start/halt launch responder; clears data memory, holds then releases the PC, freezes on halt.
// Define RUN_CTRL_WDOG_EN to add a RUN-cycle watchdog that forces halt at WDOG_LIMIT.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
`ifdef RUN_CTRL_WDOG_EN
    ,
    parameter int unsigned WDOG_LIMIT = 32'hFFFF
`endif
) (
    input logic       CLK,
    input logic       rst_n,
    run_ctrl_if.slave bus
);
    run_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_q, start_d, pc_rst_q, pc_rst_d, run_en_q, run_en_d, halt_q, halt_d;
    logic              mem_we_q, mem_we_d, busy_q, busy_d, wdog_q, wdog_d;
    logic              rise, halt_go, wdog_hit;
    logic [CNT_W-1:0]  cycle_cnt, instr_cnt;

`ifdef RUN_CTRL_WDOG_EN
    assign wdog_hit = cycle_cnt == CNT_W'(WDOG_LIMIT - 1);
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        start_d = bus.start;
        rise    = bus.start & ~start_q;
        halt_go = bus.halt_req & ~bus.stall;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rise ? CLEAR : IDLE;
            CLEAR:   state_d = (addr_q == '1) ? ARMED : CLEAR;
            ARMED:   state_d = bus.start ? ARMED : RUN;
            RUN:     state_d = rise ? CLEAR : (halt_go || wdog_hit) ? DONE : RUN;
            DONE:    state_d = rise ? CLEAR : DONE;
            default: state_d = IDLE;
        endcase
        // The sweep address wraps to 0 on its last step, so it is 0 again outside CLEAR.
        addr_d   = (state_q == CLEAR) ? addr_q + 1'b1 : '0;
        pc_rst_d = state_d inside {IDLE, CLEAR, ARMED};
        run_en_d = state_d == RUN;
        halt_d   = state_d == DONE;
        mem_we_d = state_d == CLEAR;
        busy_d   = state_d == CLEAR;
        wdog_d   = (state_d == CLEAR) ? 1'b0 :
                   (state_q == RUN && state_d == DONE && !halt_go) ? 1'b1 : wdog_q;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            start_q  <= 1'b0;
            pc_rst_q <= 1'b1;
            run_en_q <= 1'b0;
            halt_q   <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            wdog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            pc_rst_q <= pc_rst_d;
            run_en_q <= run_en_d;
            halt_q   <= halt_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
            wdog_q   <= wdog_d;
        end
    end

    sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk(CLK), .rst_n(rst_n), .clr(state_d == CLEAR), .inc(state_q == RUN), .cnt(cycle_cnt)
    );
    sat_cnt #(.W(CNT_W)) u_instr_cnt (
        .clk(CLK), .rst_n(rst_n), .clr(state_d == CLEAR), .inc(state_q == RUN && !bus.stall), .cnt(instr_cnt)
    );

    assign bus.pc_rst    = pc_rst_q;
    assign bus.run_en    = run_en_q;
    assign bus.halt      = halt_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = DATA_W'(0);
    assign bus.busy      = busy_q;
    assign bus.cycle_cnt = cycle_cnt;
    assign bus.instr_cnt = instr_cnt;
    assign bus.wdog_to   = wdog_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed launch/run/abort sequence with randomized run traffic for run_ctrl.
// Build with RUN_CTRL_WDOG_EN to exercise the watchdog at WDOG_LIMIT=20.
module tb_run_ctrl;
`ifdef RUN_CTRL_WDOG_EN
    localparam int WDOG_LIMIT = 20;
`endif
    localparam int WORDS = 256;

    logic CLK = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   hq [1:128];
    bit   st [1:128];

    run_ctrl_if bus ();
`ifdef RUN_CTRL_WDOG_EN
    run_ctrl #(.WDOG_LIMIT(WDOG_LIMIT)) dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));
`else
    run_ctrl dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));
`endif

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc_rst"}, bus.pc_rst, 1);
        chk({tag, ".run_en"}, bus.run_en, 0);
        chk({tag, ".halt"}, bus.halt, 0);
        chk({tag, ".mem_we"}, bus.mem_we, 0);
        chk({tag, ".mem_addr"}, bus.mem_addr, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".cycle_cnt"}, bus.cycle_cnt, 0);
        chk({tag, ".instr_cnt"}, bus.instr_cnt, 0);
        chk({tag, ".wdog_to"}, bus.wdog_to, 0);
    endtask

    // Raise start (rise seen on the next clock, numbered 1), drop it after clock drop_at,
    // optionally pulse it low for 4 clocks from glitch_at, and follow the launch into RUN.
    task automatic sweep(input string tag, input int drop_at, input int glitch_at);
        int wr = 0, first = -1, run_at = -1, exp_run;
        bit addr_ok = 1, side_ok = 1;
        exp_run = (drop_at + 1 > WORDS + 2) ? drop_at + 1 : WORDS + 2;
        bus.start = 1'b1;
        for (int c = 1; c <= 400 && run_at < 0; c++) begin
            step();
            if (c == 1) begin
                chk({tag, ".entry_halt"}, bus.halt, 0);
                chk({tag, ".entry_we"}, bus.mem_we, 1);
                chk({tag, ".entry_cycle"}, bus.cycle_cnt, 0);
                chk({tag, ".entry_instr"}, bus.instr_cnt, 0);
                chk({tag, ".entry_wdog"}, bus.wdog_to, 0);
            end
            if (bus.mem_we === 1'b1) begin
                if (first < 0) first = c;
                addr_ok &= int'(bus.mem_addr) == wr;
                wr++;
            end
            if (bus.run_en === 1'b1) run_at = c;
            else side_ok &= bus.pc_rst === 1'b1 && bus.halt === 1'b0 && bus.busy === bus.mem_we &&
                            bus.mem_wdata === 8'h00 && (bus.mem_we === 1'b1 || bus.mem_addr === 8'h00) &&
                            bus.cycle_cnt === 16'h0 && bus.instr_cnt === 16'h0;
            bus.halt_req = 1'($urandom_range(1));
            bus.stall = 1'($urandom_range(1));
            if (glitch_at > 0 && c == glitch_at) bus.start = 1'b0;
            if (glitch_at > 0 && c == glitch_at + 4) bus.start = 1'b1;
            if (c == drop_at) bus.start = 1'b0;
        end
        bus.halt_req = 1'b0;
        bus.stall = 1'b0;
        chk({tag, ".writes"}, wr, WORDS);
        chk({tag, ".first_write"}, first, 1);
        chk({tag, ".addr_seq"}, addr_ok, 1);
        chk({tag, ".hold_outputs"}, side_ok, 1);
        chk({tag, ".run_at"}, run_at, exp_run);
        chk({tag, ".run_pc_rst"}, bus.pc_rst, 0);
    endtask

    // Reference: halt lands on the first RUN cycle with halt_req and no stall (or the
    // watchdog cycle); instructions retired are the non-stall cycles up to and including it.
    task automatic run_check(input string tag, input int n);
        int k = 0, instr = 0, last;
        bit wd = 0, seq_ok = 1;
        for (int i = 1; i <= n && k == 0; i++) if (hq[i] && !st[i]) k = i;
`ifdef RUN_CTRL_WDOG_EN
        if (k == 0 || k > WDOG_LIMIT) begin
            k = WDOG_LIMIT;
            wd = 1;
        end
`endif
        for (int i = 1; i <= k; i++) instr += int'(!st[i]);
        last = (n > k ? n : k) + 2;
        for (int i = 1; i <= last; i++) begin
            bus.halt_req = hq[i];
            bus.stall = st[i];
            step();
            seq_ok &= bus.run_en === (i < k) && bus.halt === (i >= k) && bus.pc_rst === 1'b0 &&
                      bus.mem_we === 1'b0 && bus.cycle_cnt === 16'(i < k ? i : k);
        end
        bus.halt_req = 1'b0;
        bus.stall = 1'b0;
        chk({tag, ".sequence"}, seq_ok, 1);
        chk({tag, ".halt"}, bus.halt, 1);
        chk({tag, ".cycle_cnt"}, bus.cycle_cnt, k);
        chk({tag, ".instr_cnt"}, bus.instr_cnt, instr);
        chk({tag, ".wdog_to"}, bus.wdog_to, wd);
    endtask

    task automatic clr_stim();
        for (int i = 1; i <= 128; i++) begin
            hq[i] = 1'b0;
            st[i] = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.start = 1'b1;
        bus.halt_req = 1'b0;
        bus.stall = 1'b0;
        #2 rst_n = 1'b0;
        #2 chk_reset("por");
        step();
        step();
        chk_reset("por_held");
        #2 rst_n = 1'b1;

        sweep("boot", 299, 0);
        clr_stim();
        hq[10] = 1'b1;
        run_check("halt10", 10);

        sweep("relaunch", 20, 0);
        clr_stim();
        for (int i = 1; i <= 12; i += 2) st[i] = 1'b1;
        hq[3] = 1'b1;
        hq[5] = 1'b1;
        hq[8] = 1'b1;
        run_check("stall_odd", 12);

        sweep("glitch", 270, 40);
        for (int r = 0; r < 4; r++) begin
            int n;
            sweep("rand_sweep", int'($urandom_range(280, 1)), 0);
            clr_stim();
            n = int'($urandom_range(40, 5));
            for (int i = 1; i < n; i++) begin
                hq[i] = $urandom_range(99) < 8;
                st[i] = $urandom_range(99) < 30;
            end
            hq[n] = 1'b1;
            run_check("rand_run", n);
        end

        sweep("wdog_sweep", 5, 0);
        clr_stim();
        hq[110] = 1'b1;
        run_check("long_run", 110);

        sweep("abort_sweep", 280, 0);
        for (int i = 1; i <= 5; i++) begin
            bus.start = (i == 5);
            step();
        end
        chk("abort.run_en", bus.run_en, 0);
        chk("abort.halt", bus.halt, 0);
        chk("abort.mem_we", bus.mem_we, 1);
        chk("abort.mem_addr", bus.mem_addr, 0);
        chk("abort.cycle_cnt", bus.cycle_cnt, 0);
        begin
            int c = 0;
            while (bus.mem_addr !== 8'h40 && c < 100) begin
                step();
                c++;
            end
            chk("abort.reach_40", bus.mem_addr, 8'h40);
        end
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        step();
        step();
        chk_reset("rst_held");
        #2 rst_n = 1'b1;
        sweep("post_rst", 150, 0);
        clr_stim();
        hq[3] = 1'b1;
        run_check("final", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Processor-side responder for the start/halt launch protocol driven by the bench/host.
- Start held high: sweeps data memory to zero through a dedicated write port, then holds the core's PC in reset.
- Start released: enables execution.
- Decoded halt instruction: freezes the core and raises halt.
- Sits in TopLevel between the external start/halt pins, the PC/fetch logic and data_mem write-port arbitration.

Parameters:
ADDR_W, 8, data memory address width; clear sweep covers 2**ADDR_W entries
DATA_W, 8, data memory word width
CNT_W, 16, width of cycle and retired-instruction counters
WDOG_LIMIT, 16'hFFFF, RUN-cycle count at which the watchdog forces halt (only with RUN_CTRL_WDOG_EN)

Ports:
CLK  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  host launch: high = hold/clear, falling level = run
halt_req  in  1  decoder flags halt instruction in current cycle
stall  in  1  core stall; instruction not retiring this cycle
pc_rst  out  1  hold PC at 0
run_en  out  1  PC advance / register-write enable
halt  out  1  done flag to host
mem_we  out  1  clear-sweep write strobe to data_mem
mem_addr  out  ADDR_W  clear-sweep address
mem_wdata  out  DATA_W  clear data, constant 0
busy  out  1  high in CLEAR
cycle_cnt  out  CNT_W  RUN cycles since launch
instr_cnt  out  CNT_W  retired instructions since launch
wdog_to  out  1  halt caused by watchdog

Behaviour:
- States: IDLE, CLEAR, ARMED, RUN, DONE. All outputs registered.
- Reset values: state IDLE, pc_rst=1, run_en=0, halt=0, mem_we=0, mem_addr=0, busy=0, counters 0, wdog_to=0, start_q=0.
- Start edge detect: start_q is start registered; rise = start & ~start_q.
  - start already high when rst_n deasserts counts as a rise on the first clock.
- IDLE: pc_rst=1. On rise -> CLEAR.
- CLEAR:
  - mem_we=1 and busy=1 every cycle.
  - mem_addr steps 0,1,...,2**ADDR_W-1, one per cycle: exactly 256 writes for the default.
  - Counters and wdog_to are zeroed on entry.
  - After the write to the last address -> ARMED. mem_addr wraps to 0 with mem_we=0.
  - start is not sampled during CLEAR: a low pulse is ignored and the sweep always completes.
- ARMED: pc_rst=1, run_en=0. When start==0 -> RUN. If start is already low at sweep end, RUN follows the cycle after the last write.
- RUN:
  - pc_rst=0; run_en=1 in the first RUN cycle.
  - cycle_cnt +1 every cycle. instr_cnt +1 when ~stall. Both saturate at all-ones.
  - halt_req && ~stall -> DONE. halt_req while stall is ignored that cycle.
  - A start rise mid-RUN aborts: -> CLEAR, run_en=0 on the next cycle, halt stays 0.
- DONE:
  - halt=1, run_en=0, pc_rst=0 (PC frozen for inspection); counters held.
  - Stays until a start rise -> CLEAR, where halt drops to 0 on entry.
- Latency:
  - halt rises the cycle after the qualifying halt_req edge.
  - run_en drops on that same edge, so the halt instruction is the last one retired and is counted in instr_cnt.
- halt_req in IDLE, CLEAR, ARMED or DONE is ignored.
- Asserting rst_n low in any state returns immediately to the reset values. A sweep interrupted this way is abandoned, not resumed.

Optional Feature:
RUN_CTRL_WDOG_EN
- Defined: in RUN, when cycle_cnt == WDOG_LIMIT-1 and no halt this cycle -> DONE with wdog_to=1. wdog_to is held until the next CLEAR.
- Undefined: no watchdog logic, wdog_to tied 0, and RUN lasts until halt_req or abort. WDOG_LIMIT is unused.

Decomposition:
- Package run_ctrl_pkg holds:
  - the state enum run_state_t {IDLE, CLEAR, ARMED, RUN, DONE};
  - default width constants ADDR_W_DEF=8, DATA_W_DEF=8, CNT_W_DEF=16.
- One sub-module, sat_cnt (parameterised width; synchronous clear, increment enable, saturate at max), instantiated twice for cycle_cnt and instr_cnt.
- The FSM and the sweep address counter stay in run_ctrl.

Test Plan:
- start=1 through reset release, start=0 at the 300th clock -> mem_we high for exactly 256 cycles with addresses 0x00..0xFF, then ARMED; run_en rises the cycle after start samples 0; halt=0 throughout.
- RUN with stall=0, halt_req pulsed on the 10th RUN cycle -> halt=1 the next cycle, run_en=0, instr_cnt=10, cycle_cnt=10.
- RUN with stall on every odd cycle and halt_req asserted together with stall -> no halt; halt occurs on the next non-stall halt_req; instr_cnt equals the number of non-stall cycles.
- From DONE, raise start -> halt drops on CLEAR entry, counters read 0, full 256-entry sweep repeats.
- Abort: start rises on the 5th RUN cycle -> CLEAR next cycle, run_en=0, halt stays 0; rst_n pulsed low at sweep address 0x40 -> all outputs at reset values asynchronously.
- With RUN_CTRL_WDOG_EN and WDOG_LIMIT=20, halt_req never asserted -> halt=1 and wdog_to=1 after 20 RUN cycles. Without the macro, the same stimulus keeps halt=0 beyond 100 cycles.
